// File: rtl/rv_pkg.sv
// Shared definitions for the register-file access path: widths, the access
// controller's state type and the buffered write entry.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 5;

  localparam logic [IDX_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RS1 = 2'd1,
    RD_RS2 = 2'd2
  } rfac_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding writeback entries until the register-file
// port is free. Async active-high reset clears pointers and count only.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap explicitly so non-power-of-two depths also stay in range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates the single register-file port between decode's two-source reads
// and writeback's buffered writes; buffered writes always drain before a read.
module regfile_access_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [IDX_W-1:0] rs1,
  input  logic [IDX_W-1:0] rs2,
  output logic             rd_rsp_valid,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [31:0]      rf_register,
  output logic             rf_writeEnable,
  output logic [XLEN-1:0]  rf_writeData,
  input  logic [XLEN-1:0]  rf_readData
);

  rfac_state_t      state_r;
  rfac_state_t      next_state_s;
  logic [IDX_W-1:0] rs1_idx_r;
  logic [IDX_W-1:0] rs2_idx_r;
  logic [XLEN-1:0]  rs1_data_r;
  logic [XLEN-1:0]  rs2_data_r;
  logic             rsp_valid_r;

  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  wb_entry_t        entry_in_s;
  wb_entry_t        head_s;
  logic [IDX_W-1:0] rf_idx_s;
  logic             rf_we_s;
  logic [XLEN-1:0]  rf_wd_s;

  // x0 writes are handshaken like any other but never reach the buffer.
  assign wb_ready   = !fifo_full_s;
  assign push_s     = wb_valid && !fifo_full_s && (wb_rd != ZERO_REG);
  assign entry_in_s = '{rd: wb_rd, data: wb_data};

  wb_fifo #(
    .DEPTH (WB_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (entry_in_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Port mux and next-state: drain first, then reads only when no write is pending or offered.
  always_comb begin
    next_state_s = state_r;
    rf_idx_s     = ZERO_REG;
    rf_we_s      = 1'b0;
    rf_wd_s      = {XLEN{1'b0}};
    pop_s        = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          rf_idx_s = head_s.rd;
          rf_we_s  = 1'b1;
          rf_wd_s  = head_s.data;
          pop_s    = 1'b1;
        end else if (rd_req_valid && !wb_valid) begin
          accept_s     = 1'b1;
          next_state_s = RD_RS1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RD_RS1: begin
        rf_idx_s     = rs1_idx_r;
        next_state_s = RD_RS2;
      end
      RD_RS2: begin
        rf_idx_s     = rs2_idx_r;
        next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  assign rd_req_ready   = accept_s;
  assign rf_register    = {{(32-IDX_W){1'b0}}, rf_idx_s};
  assign rf_writeEnable = rf_we_s;
  assign rf_writeData   = rf_wd_s;
  assign rd_rsp_valid   = rsp_valid_r;
  assign rs1_data       = rs1_data_r;
  assign rs2_data       = rs2_data_r;

  // State, latched indices and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rs1_idx_r   <= ZERO_REG;
      rs2_idx_r   <= ZERO_REG;
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      rsp_valid_r <= (state_r == RD_RS2);
      if (accept_s) begin
        rs1_idx_r <= rs1;
        rs2_idx_r <= rs2;
      end
      if (state_r == RD_RS1) rs1_data_r <= rf_readData;
      if (state_r == RD_RS2) rs2_data_r <= rf_readData;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a transaction-level model of the access rules.
module tb_regfile_access_ctrl;

  localparam int WB_DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [4:0]  rs1, rs2;
  logic        rd_rsp_valid;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rf_register;
  logic        rf_writeEnable;
  logic [31:0] rf_writeData;
  logic [31:0] rf_readData;

  logic [31:0] rf_mem [32] = '{default: 32'h0};

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state
  wr_t         wq[$];
  logic [31:0] golden [32];
  logic        have_rd;
  int          acc_cyc;
  int          cyc = 0;
  logic [4:0]  r1q, r2q;
  logic [31:0] exp_rs1, exp_rs2;
  logic        last_wb_acc, last_rd_acc;

  regfile_access_ctrl #(.WB_DEPTH(WB_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd_rsp_valid   (rd_rsp_valid),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .rf_register    (rf_register),
    .rf_writeEnable (rf_writeEnable),
    .rf_writeData   (rf_writeData),
    .rf_readData    (rf_readData)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write on the clock edge.
  assign rf_readData = rf_mem[rf_register[4:0]];
  always_ff @(posedge clk) begin
    if (rf_writeEnable) rf_mem[rf_register[4:0]] <= rf_writeData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    wq.delete();
    have_rd = 1'b0;
    exp_rs1 = 32'h0;
    exp_rs2 = 32'h0;
  endtask

  // One clock cycle: inputs already driven at the falling edge.
  task automatic tick();
    logic busy1, busy2, rsp_now, exp_wbr, exp_drain, exp_rdr;
    logic [31:0] exp_reg, exp_wd;
    #1;
    busy1     = have_rd && (cyc == acc_cyc + 1);
    busy2     = have_rd && (cyc == acc_cyc + 2);
    rsp_now   = have_rd && (cyc == acc_cyc + 3);
    exp_wbr   = (wq.size() < WB_DEPTH);
    exp_drain = !busy1 && !busy2 && (wq.size() != 0);
    exp_rdr   = rd_req_valid && !busy1 && !busy2 && (wq.size() == 0) && !wb_valid;
    exp_reg   = 32'h0;
    exp_wd    = 32'h0;
    if (exp_drain) begin
      exp_reg = {27'h0, wq[0].rd};
      exp_wd  = wq[0].data;
    end else if (busy1) begin
      exp_reg = {27'h0, r1q};
    end else if (busy2) begin
      exp_reg = {27'h0, r2q};
    end
    chk("wb_ready", {31'h0, wb_ready}, {31'h0, exp_wbr});
    chk("rd_req_ready", {31'h0, rd_req_ready}, {31'h0, exp_rdr});
    chk("rf_writeEnable", {31'h0, rf_writeEnable}, {31'h0, exp_drain});
    chk("rf_register", rf_register, exp_reg);
    if (!busy1 && !busy2) chk("rf_writeData", rf_writeData, exp_wd);
    chk("rd_rsp_valid", {31'h0, rd_rsp_valid}, {31'h0, rsp_now});
    chk("rs1_data", rs1_data, exp_rs1);
    chk("rs2_data", rs2_data, exp_rs2);
    // Model update for the coming edge
    if (busy1) exp_rs1 = golden[r1q];
    if (busy2) exp_rs2 = golden[r2q];
    if (rsp_now) have_rd = 1'b0;
    if (exp_drain) begin
      golden[wq[0].rd] = wq[0].data;
      void'(wq.pop_front());
    end
    last_wb_acc = wb_valid && exp_wbr;
    if (last_wb_acc && wb_rd != 5'd0) wq.push_back('{rd: wb_rd, data: wb_data});
    last_rd_acc = exp_rdr;
    if (exp_rdr) begin
      have_rd = 1'b1;
      acc_cyc = cyc;
      r1q     = rs1;
      r2q     = rs2;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_wb_acc) break;
    end
    if (!last_wb_acc) begin
      total_cnt++;
      $display("FAIL wr_timeout observed=not accepted expected=accepted rd=%0d", rd);
    end
    wb_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b);
    rd_req_valid = 1'b1; rs1 = a; rs2 = b;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_rd_acc) break;
    end
    if (!last_rd_acc) begin
      total_cnt++;
      $display("FAIL rd_timeout observed=not accepted expected=accepted rs1=%0d", a);
    end
    rd_req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) golden[i] = 32'h0;
    model_reset();
    rst = 1'b1; rd_req_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    last_wb_acc = 1'b0; last_rd_acc = 1'b0; r1q = 5'd0; r2q = 5'd0; acc_cyc = 0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_rsp_valid", {31'h0, rd_rsp_valid}, 32'h0);
    chk("rst_rs1_data", rs1_data, 32'h0);
    chk("rst_rs2_data", rs2_data, 32'h0);
    chk("rst_wb_ready", {31'h0, wb_ready}, 32'h1);
    chk("rst_rf_we", {31'h0, rf_writeEnable}, 32'h0);
    chk("rst_rf_register", rf_register, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Basic read after preload
    do_write(5'd3, 32'h11);
    do_write(5'd5, 32'h22);
    do_write(5'd9, 32'h55);
    idle(3);
    do_read(5'd3, 5'd5);
    idle(3);
    chk("t1_rs1", rs1_data, 32'h11);
    chk("t1_rs2", rs2_data, 32'h22);

    // 2. Same-cycle write and read: the write is older
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    rd_req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd3;
    tick();
    wb_valid = 1'b0;
    tick();
    tick();
    rd_req_valid = 1'b0;
    idle(4);
    chk("t2_rs1", rs1_data, 32'hDEADBEEF);

    // 3. Buffer fills while a read is in flight
    do_read(5'd1, 5'd2);
    do_write(5'd10, 32'hA0A0_0001);
    do_write(5'd11, 32'hB0B0_0002);
    do_write(5'd12, 32'hC0C0_0003);
    idle(4);
    do_read(5'd10, 5'd12);
    idle(4);
    chk("t3_rs1", rs1_data, 32'hA0A0_0001);
    chk("t3_rs2", rs2_data, 32'hC0C0_0003);

    // 4. x0 write is discarded
    do_write(5'd0, 32'hFFFFFFFF);
    idle(2);
    do_read(5'd0, 5'd11);
    idle(4);
    chk("t4_x0", rs1_data, 32'h0);
    chk("t4_rs2", rs2_data, 32'hB0B0_0002);

    // 5. Reset during RD_RS2 with one buffered write
    do_read(5'd9, 5'd3);
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    tick();
    wb_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", {31'h0, rd_rsp_valid}, 32'h0);
    chk("t5_rs1_data", rs1_data, 32'h0);
    chk("t5_rs2_data", rs2_data, 32'h0);
    chk("t5_rf_we", {31'h0, rf_writeEnable}, 32'h0);
    chk("t5_rf_register", rf_register, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    do_read(5'd9, 5'd5);
    idle(4);
    chk("t5_dropped_write", rs1_data, 32'h55);

    // 6. Back-to-back reads
    rd_req_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd7;
    idle(10);
    rd_req_valid = 1'b0;
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data      = $urandom;
      rd_req_valid = ($urandom_range(0, 1) == 1);
      rs1          = 5'($urandom_range(0, 31));
      rs2          = 5'($urandom_range(0, 31));
      tick();
    end
    wb_valid = 1'b0; rd_req_valid = 1'b0;
    idle(6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
